// File: rtl/calc_pkg.sv
// Shared calculator constants, FSM encodings and the BCD digit-count sizing check.
package calc_pkg;

    localparam int ALU_W = 8;
    localparam int BCD_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // True when `digits` decimal digits can hold the largest `width`-bit unsigned value.
    function automatic bit digits_ok(input int width, input int digits);
        longint unsigned p = 1;
        longint unsigned maxv;
        for (int i = 0; i < digits; i++) p = p * 10;
        maxv = (64'd1 << width) - 64'd1;
        return p > maxv;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3
    import calc_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with optional two's-complement input.
// One bit per cycle; result and sign are registered on the final shift together with done.
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int WIDTH  = ALU_W,
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    signed_mode,
    input  logic [WIDTH-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic                    neg,
    output logic [BCD_W*DIGITS-1:0] bcd
);

    localparam int BW    = BCD_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mag;
    logic [BW-1:0]    bcd_work;
    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    work_nxt;
    logic             sign_latch;
    logic             last_shift;
    logic             load_neg;

    // Per-digit +3 correction applied ahead of every shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (bcd_work[g*BCD_W +: BCD_W]),
            .dout (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    // Next BCD accumulator: corrected digits shifted left, taking the magnitude MSB in
    assign work_nxt   = {bcd_adj[BW-2:0], mag[WIDTH-1]};
    assign last_shift = (cnt == CNT_W'(WIDTH - 1));
    assign load_neg   = signed_mode & bin[WIDTH-1];
    assign busy       = (state == ST_SHIFT);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: IDLE waits for start, SHIFT runs WIDTH cycles then returns
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)      state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand load, shift/correct loop and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            mag        <= '0;
            bcd_work   <= '0;
            sign_latch <= 1'b0;
            done       <= 1'b0;
            neg        <= 1'b0;
            bcd        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt        <= '0;
                        bcd_work   <= '0;
                        sign_latch <= load_neg;
                        mag        <= load_neg ? (~bin + WIDTH'(1)) : bin;
                    end
                end
                ST_SHIFT: begin
                    bcd_work <= work_nxt;
                    mag      <= mag << 1;
                    cnt      <= cnt + CNT_W'(1);
                    if (last_shift) begin
                        bcd  <= work_nxt;
                        neg  <= sign_latch;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes expected results, a monitor pops on done.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic        neg;
    logic [11:0] bcd;

    int passed = 0;
    int total  = 0;
    logic [12:0] sb[$];
    logic [12:0] last_res;
    logic        prev_done = 1'b0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .bin         (bin),
        .busy        (busy),
        .done        (done),
        .neg         (neg),
        .bcd         (bcd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected {neg, bcd} computed with plain decimal arithmetic
    function automatic logic [12:0] model(input logic sm, input logic [7:0] v);
        logic n;
        int   m;
        n = sm & v[7];
        m = n ? 256 - int'(v) : int'(v);
        return {n, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Monitor: every done pulse must match the oldest expected result and be one cycle wide
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                chk("result", 32'({neg, bcd}), 32'(sb[0]));
                void'(sb.pop_front());
            end
            chk("done_one_cycle", 32'(prev_done), 32'(0));
        end
        prev_done = done;
    end

    // Issue one conversion (start already legal), check busy/hold/latency until done.
    // inj: assert start with 99 two edges after acceptance, which must be ignored.
    task automatic convert(input logic sm, input logic [7:0] v, input bit inj);
        int  lat = 0;
        logic [12:0] exp;
        exp = model(sm, v);
        sb.push_back(exp);
        start = 1'b1; signed_mode = sm; bin = v;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin lat = k; break; end
            chk("busy_during", 32'(busy), 32'(1));
            chk("hold_prev", 32'({neg, bcd}), 32'(last_res));
            if (inj && k == 2) begin start = 1'b1; bin = 8'd99; end
        end
        chk("latency", 32'(lat), 32'(8));
        last_res = exp;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; signed_mode = 1'b0; bin = 8'd77;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_out", 32'({neg, bcd}), 32'(0));
        start = 1'b0; rst_n = 1'b1; last_res = '0;
        @(posedge clk); #1;

        convert(1'b0, 8'd255, 1'b0);
        chk("t1_bcd", 32'(bcd), 32'h255);
        convert(1'b0, 8'd0, 1'b0);
        convert(1'b0, 8'd100, 1'b0);
        chk("t2_bcd", 32'(bcd), 32'h100);
        convert(1'b1, 8'h80, 1'b0);
        chk("t3_min", 32'({neg, bcd}), 32'h1128);
        convert(1'b1, 8'hFF, 1'b0);
        convert(1'b1, 8'h7F, 1'b0);
        chk("t3_max", 32'({neg, bcd}), 32'h0127);
        convert(1'b1, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        convert(1'b0, 8'd42, 1'b1);
        chk("t4_ignored", 32'(bcd), 32'h042);
        // Start in the done cycle: back-to-back acceptance
        convert(1'b0, 8'd7, 1'b0);
        chk("t5_b2b", 32'(bcd), 32'h007);

        // Reset mid-conversion
        start = 1'b1; signed_mode = 1'b0; bin = 8'd200;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t6_busy", 32'(busy), 32'(0));
        chk("t6_out", 32'({neg, bcd}), 32'(0));
        last_res = '0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            chk("t6_no_done", 32'(done), 32'(0));
        end

        // Exhaustive sweep, both modes, back to back
        for (int m = 0; m < 2; m++)
            for (int v = 0; v < 256; v++)
                convert(m[0], 8'(v), 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
